// File: rtl/extremum_pkg.sv
// Shared definitions for the extremum scheduler: FSM encoding, channel indices
// and the signed extreme values used to seed min/max trackers.
package extremum_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARM     = 3'd1;
  localparam logic [2:0] ST_MEASURE = 3'd2;
  localparam logic [2:0] ST_PUBLISH = 3'd3;
  localparam logic [2:0] ST_HOLDOFF = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    ARM     = ST_ARM,
    MEASURE = ST_MEASURE,
    PUBLISH = ST_PUBLISH,
    HOLDOFF = ST_HOLDOFF
  } state_t;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  // Largest positive / most negative two's complement value of a w-bit word.
  function automatic logic [31:0] max_pos(input int w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  function automatic logic [31:0] max_neg(input int w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/ef_minmax_accumulator.sv
// Tracks signed min/max over a window of 2^log_count accepted samples and
// flags the sample that completes the window.
module ef_minmax_accumulator
  import extremum_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         SYS_aclk,
  input  logic         SYS_areset,
  input  logic         clear,
  input  logic         sample_valid,
  input  logic [W-1:0] sample,
  input  logic [4:0]   log_count,
  output logic [W-1:0] tmp_min,
  output logic [W-1:0] tmp_max,
  output logic         done
);

  localparam logic [W-1:0] INIT_MIN = W'(max_pos(W));
  localparam logic [W-1:0] INIT_MAX = W'(max_neg(W));

  logic [31:0] count;
  logic [31:0] count_next;
  logic [31:0] target;

  assign count_next = count + 32'd1;
  assign target     = 32'd1 << log_count;
  assign done       = sample_valid && (count_next == target);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create ordering-dependent races.
  always_ff @(posedge SYS_aclk) begin
    if (SYS_areset || clear) begin
      tmp_min <= INIT_MIN;
      tmp_max <= INIT_MAX;
      count   <= '0;
    end else if (sample_valid) begin
      if ($signed(sample) < $signed(tmp_min)) tmp_min <= sample;
      if ($signed(sample) > $signed(tmp_max)) tmp_max <= sample;
      count <= count_next;
    end
  end

endmodule

// File: rtl/extremum_scheduler.sv
// Round-robin min/max measurement of the two halves of an ADC stream word,
// publishing narrowed per-channel thresholds after each window.
module extremum_scheduler
  import extremum_pkg::*;
#(
  parameter  int AXIS_TDATA_WIDTH = 32,
  parameter  int HOLDOFF_WIDTH    = 16,
  localparam int W                = AXIS_TDATA_WIDTH / 2
) (
  input  logic                        SYS_aclk,
  input  logic                        SYS_areset,
  input  logic                        S_AXIS_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  output logic                        S_AXIS_tready,
  input  logic                        EF_enable,
  input  logic [1:0]                  EF_channel_mask,
  input  logic [4:0]                  EF_log_count,
  input  logic [2:0]                  EF_shift,
  input  logic [HOLDOFF_WIDTH-1:0]    EF_holdoff,
  output logic [W-1:0]                EF_lower_threshold_a,
  output logic [W-1:0]                EF_upper_threshold_a,
  output logic [W-1:0]                EF_lower_threshold_b,
  output logic [W-1:0]                EF_upper_threshold_b,
  output logic [1:0]                  EF_update,
  output logic                        EF_busy,
  output logic                        EF_active_channel
);

  localparam logic [W-1:0] RST_LOWER = W'(max_pos(W));
  localparam logic [W-1:0] RST_UPPER = W'(max_neg(W));

  state_t                   state, state_next;
  logic                     ptr, sel_ch, pick_ch;
  logic [4:0]               lat_log;
  logic [2:0]               lat_shift;
  logic [HOLDOFF_WIDTH-1:0] lat_holdoff, hold_cnt;
  logic                     hold_last, run_ok;
  logic [W-1:0]             acc_sample, tmp_min, tmp_max;
  logic                     acc_done;
  logic signed [W:0]        min_x, max_x, center, lower_x, upper_x;

  assign S_AXIS_tready     = 1'b1;
  assign EF_busy           = (state != IDLE);
  assign EF_active_channel = sel_ch;
  assign run_ok            = EF_enable && (EF_channel_mask != 2'b00);
  assign pick_ch           = EF_channel_mask[ptr] ? ptr : ~ptr;
  assign hold_last         = (hold_cnt == lat_holdoff - HOLDOFF_WIDTH'(1));
  assign acc_sample        = (sel_ch == CH_B) ? S_AXIS_tdata[AXIS_TDATA_WIDTH-1:W]
                                              : S_AXIS_tdata[W-1:0];

  ef_minmax_accumulator #(.W(W)) u_acc (
    .SYS_aclk     (SYS_aclk),
    .SYS_areset   (SYS_areset),
    .clear        (state == ARM),
    .sample_valid ((state == MEASURE) && S_AXIS_tvalid),
    .sample       (acc_sample),
    .log_count    (lat_log),
    .tmp_min      (tmp_min),
    .tmp_max      (tmp_max),
    .done         (acc_done)
  );

  // One extra bit keeps the midpoint and the offsets from overflowing.
  always_comb begin
    min_x   = {tmp_min[W-1], tmp_min};
    max_x   = {tmp_max[W-1], tmp_max};
    center  = (max_x + min_x) >>> 1;
    lower_x = ((min_x - center) >>> lat_shift) + center;
    upper_x = ((max_x - center) >>> lat_shift) + center;
  end

  // NOTE: next state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (run_ok) state_next = ARM;
      ARM:     state_next = run_ok ? MEASURE : IDLE;
      MEASURE: begin
        if (!EF_enable)    state_next = IDLE;
        else if (acc_done) state_next = PUBLISH;
      end
      PUBLISH: begin
        if (!EF_enable)                state_next = IDLE;
        else if (lat_holdoff == '0)    state_next = run_ok ? ARM : IDLE;
        else                           state_next = HOLDOFF;
      end
      HOLDOFF: begin
        if (!EF_enable)     state_next = IDLE;
        else if (hold_last) state_next = run_ok ? ARM : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge SYS_aclk) begin
    if (SYS_areset) begin
      state                <= IDLE;
      ptr                  <= CH_A;
      sel_ch               <= CH_A;
      lat_log              <= '0;
      lat_shift            <= '0;
      lat_holdoff          <= '0;
      hold_cnt             <= '0;
      EF_lower_threshold_a <= RST_LOWER;
      EF_upper_threshold_a <= RST_UPPER;
      EF_lower_threshold_b <= RST_LOWER;
      EF_upper_threshold_b <= RST_UPPER;
      EF_update            <= 2'b00;
    end else begin
      state     <= state_next;
      EF_update <= 2'b00;
      unique case (state)
        ARM: if (run_ok) begin
          lat_log     <= EF_log_count;
          lat_shift   <= EF_shift;
          lat_holdoff <= EF_holdoff;
          sel_ch      <= pick_ch;
        end
        PUBLISH: begin
          if (sel_ch == CH_B) begin
            EF_lower_threshold_b <= lower_x[W-1:0];
            EF_upper_threshold_b <= upper_x[W-1:0];
            EF_update            <= 2'b10;
          end else begin
            EF_lower_threshold_a <= lower_x[W-1:0];
            EF_upper_threshold_a <= upper_x[W-1:0];
            EF_update            <= 2'b01;
          end
          ptr      <= ~sel_ch;
          hold_cnt <= '0;
        end
        HOLDOFF: hold_cnt <= hold_cnt + HOLDOFF_WIDTH'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_extremum_scheduler.sv
// Scoreboard bench: stimulus pushes expected publications, a negedge monitor
// pops and compares them against the strobe, its cycle and all thresholds.
module tb_extremum_scheduler;

  logic        SYS_aclk = 1'b0;
  logic        SYS_areset;
  logic        S_AXIS_tvalid;
  logic [31:0] S_AXIS_tdata;
  logic        S_AXIS_tready;
  logic        EF_enable;
  logic [1:0]  EF_channel_mask;
  logic [4:0]  EF_log_count;
  logic [2:0]  EF_shift;
  logic [15:0] EF_holdoff;
  logic [15:0] EF_lower_threshold_a, EF_upper_threshold_a;
  logic [15:0] EF_lower_threshold_b, EF_upper_threshold_b;
  logic [1:0]  EF_update;
  logic        EF_busy;
  logic        EF_active_channel;

  extremum_scheduler #(.AXIS_TDATA_WIDTH(32), .HOLDOFF_WIDTH(16)) dut (
    .SYS_aclk             (SYS_aclk),
    .SYS_areset           (SYS_areset),
    .S_AXIS_tvalid        (S_AXIS_tvalid),
    .S_AXIS_tdata         (S_AXIS_tdata),
    .S_AXIS_tready        (S_AXIS_tready),
    .EF_enable            (EF_enable),
    .EF_channel_mask      (EF_channel_mask),
    .EF_log_count         (EF_log_count),
    .EF_shift             (EF_shift),
    .EF_holdoff           (EF_holdoff),
    .EF_lower_threshold_a (EF_lower_threshold_a),
    .EF_upper_threshold_a (EF_upper_threshold_a),
    .EF_lower_threshold_b (EF_lower_threshold_b),
    .EF_upper_threshold_b (EF_upper_threshold_b),
    .EF_update            (EF_update),
    .EF_busy              (EF_busy),
    .EF_active_channel    (EF_active_channel)
  );

  always #5 SYS_aclk = ~SYS_aclk;

  typedef struct { int ch; int lo; int hi; int at; } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   model_lo[2];
  int   model_hi[2];
  int   rr_ptr;
  int   last_ch;
  int   dir_q[$];
  bit   fixed_en;
  int   fixed_a, fixed_b;
  bit   small_range;
  int   gap_value = 1000;

  always @(posedge SYS_aclk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sx(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic int rnd16();
    logic [15:0] r;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  // Reference: midpoint of the window extremes, offsets narrowed by 2^shift.
  function automatic void model_thr(input int s[$], input int sh, output int lo, output int hi);
    int mn, mx, c;
    mn = s[0];
    mx = s[0];
    foreach (s[i]) begin
      if (s[i] < mn) mn = s[i];
      if (s[i] > mx) mx = s[i];
    end
    c  = (mn + mx) >>> 1;
    lo = ((mn - c) >>> sh) + c;
    hi = ((mx - c) >>> sh) + c;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    model_lo = '{32767, 32767};
    model_hi = '{-32768, -32768};
    rr_ptr   = 0;
  endtask

  // Monitor: compare each strobe against the oldest expected publication.
  always @(negedge SYS_aclk) begin
    exp_t e;
    if (!SYS_areset) begin
      if (exp_q.size() > 0 && cyc > exp_q[0].at) begin
        check("missing_update_cycle", cyc, exp_q[0].at);
        void'(exp_q.pop_front());
      end
      if (EF_update != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("unexpected_update", int'(EF_update), 0);
        end else begin
          e = exp_q.pop_front();
          model_lo[e.ch] = e.lo;
          model_hi[e.ch] = e.hi;
          check("update_strobe", int'(EF_update), (e.ch == 1) ? 2 : 1);
          check("update_cycle", cyc, e.at);
          check("lower_a", sx(EF_lower_threshold_a), model_lo[0]);
          check("upper_a", sx(EF_upper_threshold_a), model_hi[0]);
          check("lower_b", sx(EF_lower_threshold_b), model_lo[1]);
          check("upper_b", sx(EF_upper_threshold_b), model_hi[1]);
        end
      end
    end
  end

  task automatic step();
    @(posedge SYS_aclk);
    #1;
    S_AXIS_tvalid = 1'($urandom_range(0, 1));
    S_AXIS_tdata  = $urandom;
  endtask

  function automatic int next_sample(input int ch);
    if (dir_q.size() > 0) return dir_q.pop_front();
    if (fixed_en)         return (ch == 1) ? fixed_b : fixed_a;
    if (small_range)      return int'($urandom_range(0, 1000)) - 500;
    return rnd16();
  endfunction

  task automatic drive_cycle(input int ch, input bit v, input int val);
    int a, b;
    a = fixed_en ? fixed_a : rnd16();
    b = fixed_en ? fixed_b : rnd16();
    if (ch == 1) b = val;
    else         a = val;
    S_AXIS_tvalid = v;
    S_AXIS_tdata  = {16'(b), 16'(a)};
  endtask

  // Runs nwin windows from IDLE and leaves the DUT in IDLE; abort_after > 0
  // drops the enable once that many samples of the first window are in.
  task automatic run_session(input logic [1:0] mask, input int lg, input int sh, input int ho,
                             input int nwin, input int gap_mode, input int abort_after);
    int ch, cnt, val, lo, hi;
    bit v, tog;
    int smp[$];
    EF_channel_mask = mask;
    EF_log_count    = 5'(lg);
    EF_shift        = 3'(sh);
    EF_holdoff      = 16'(ho);
    EF_enable       = 1'b1;
    step();
    for (int w = 0; w < nwin; w++) begin
      ch = mask[rr_ptr] ? rr_ptr : 1 - rr_ptr;
      step();
      smp.delete();
      cnt = 0;
      tog = 1'b1;
      while (cnt < (1 << lg)) begin
        case (gap_mode)
          0:       v = 1'b1;
          1:       begin v = tog; tog = !tog; end
          default: v = 1'($urandom_range(0, 1));
        endcase
        val = v ? next_sample(ch) : gap_value;
        drive_cycle(ch, v, val);
        step();
        if (v) begin
          smp.push_back(val);
          cnt++;
        end
        if (abort_after > 0 && cnt == abort_after) begin
          EF_enable = 1'b0;
          step();
          return;
        end
      end
      model_thr(smp, sh, lo, hi);
      exp_q.push_back('{ch, lo, hi, cyc + 1});
      rr_ptr  = 1 - ch;
      last_ch = ch;
      if (w == nwin - 1) begin
        EF_enable = 1'b0;
        step();
      end else begin
        repeat (ho + 1) step();
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_lower_a"}, sx(EF_lower_threshold_a), 32767);
    check({tag, "_upper_a"}, sx(EF_upper_threshold_a), -32768);
    check({tag, "_lower_b"}, sx(EF_lower_threshold_b), 32767);
    check({tag, "_upper_b"}, sx(EF_upper_threshold_b), -32768);
    check({tag, "_update"}, int'(EF_update), 0);
    check({tag, "_busy"}, int'(EF_busy), 0);
    check({tag, "_active"}, int'(EF_active_channel), 0);
  endtask

  task automatic apply_reset();
    SYS_areset = 1'b1;
    EF_enable  = 1'b0;
    repeat (2) step();
    SYS_areset = 1'b0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    SYS_areset      = 1'b1;
    EF_enable       = 1'b0;
    EF_channel_mask = 2'b00;
    EF_log_count    = '0;
    EF_shift        = '0;
    EF_holdoff      = '0;
    S_AXIS_tvalid   = 1'b0;
    S_AXIS_tdata    = '0;
    fixed_en        = 1'b0;
    small_range     = 1'b0;
    last_ch         = 0;
    model_reset();
    repeat (3) @(posedge SYS_aclk);
    #1;
    SYS_areset = 1'b0;
    check_reset_state("reset");
    check("tready", int'(S_AXIS_tready), 1);

    // Single channel A, plain min/max.
    dir_q = '{10, -20, 5, 30};
    run_session(2'b01, 2, 0, 0, 1, 0, 0);
    repeat (3) step();
    check("t1_lower_a", sx(EF_lower_threshold_a), -20);
    check("t1_upper_a", sx(EF_upper_threshold_a), 30);
    check("t1_lower_b", sx(EF_lower_threshold_b), 32767);
    check("t1_upper_b", sx(EF_upper_threshold_b), -32768);
    check("t1_busy", int'(EF_busy), 0);

    // Narrowing by one bit around a zero center.
    dir_q = '{-100, 100};
    run_session(2'b01, 1, 1, 0, 1, 0, 0);
    repeat (3) step();
    check("t2_lower_a", sx(EF_lower_threshold_a), -50);
    check("t2_upper_a", sx(EF_upper_threshold_a), 50);

    // Round-robin with holdoff, constant channel values.
    apply_reset();
    fixed_en = 1'b1;
    fixed_a  = 7;
    fixed_b  = -3;
    run_session(2'b11, 3, 0, 5, 3, 0, 0);
    fixed_en = 1'b0;
    repeat (3) step();
    check("t3_lower_a", sx(EF_lower_threshold_a), 7);
    check("t3_upper_a", sx(EF_upper_threshold_a), 7);
    check("t3_lower_b", sx(EF_lower_threshold_b), -3);
    check("t3_upper_b", sx(EF_upper_threshold_b), -3);
    check("t3_active", int'(EF_active_channel), last_ch);

    // tvalid toggling; invalid cycles carry 1000 on the measured channel.
    small_range = 1'b1;
    run_session(2'b01, 2, 0, 0, 1, 1, 0);
    small_range = 1'b0;
    repeat (3) step();
    check("t4_upper_a_below_gap", int'(sx(EF_upper_threshold_a) < gap_value), 1);

    // Abort after 2 of 4 samples.
    run_session(2'b01, 2, 0, 0, 1, 0, 2);
    check("t5_busy", int'(EF_busy), 0);
    repeat (20) step();
    check("t5_lower_a", sx(EF_lower_threshold_a), model_lo[0]);
    check("t5_upper_a", sx(EF_upper_threshold_a), model_hi[0]);

    // Randomized sessions, including 1-sample windows back to back.
    run_session(2'b11, 0, 0, 0, 4, 2, 0);
    repeat (3) step();
    for (int s = 0; s < 5; s++) begin
      run_session(2'($urandom_range(1, 3)), int'($urandom_range(0, 4)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 6)), 3, 2, 0);
      repeat (3) step();
    end

    // Full-scale extremes on channel B.
    dir_q = '{32767, -32768};
    run_session(2'b10, 1, 0, 0, 1, 0, 0);
    repeat (3) step();
    check("t6_lower_b", sx(EF_lower_threshold_b), -32768);
    check("t6_upper_b", sx(EF_upper_threshold_b), 32767);

    // Reset in the middle of a channel B window.
    EF_channel_mask = 2'b10;
    EF_log_count    = 5'd2;
    EF_holdoff      = 16'd0;
    EF_enable       = 1'b1;
    step();
    step();
    drive_cycle(1, 1'b1, 123);
    step();
    check("t6_busy_before_reset", int'(EF_busy), 1);
    check("t6_active_before_reset", int'(EF_active_channel), 1);
    SYS_areset = 1'b1;
    step();
    check_reset_state("midreset");
    SYS_areset = 1'b0;
    EF_enable  = 1'b0;
    model_reset();
    repeat (5) step();

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/extremum_scheduler.md
Name: extremum_scheduler

Overview:
- Time-multiplexes one min/max measurement engine between the two 16-bit halves of the ADC AXI-Stream word: channel A = tdata[15:0], channel B = tdata[31:16].
- Runs a measurement window of 2^EF_log_count valid samples on one channel, then publishes narrowed thresholds for that channel.
- Waits a programmable holdoff, then moves to the next enabled channel in round-robin order.
- Sits between the ADC stream splitter and the fringe-counting comparators that consume the per-channel thresholds.

Parameters:
- AXIS_TDATA_WIDTH, 32, stream width; each channel is AXIS_TDATA_WIDTH/2 bits (W), signed two's complement.
- HOLDOFF_WIDTH, 16, width of the holdoff cycle counter.

Ports:
- SYS_aclk  in  1  single clock; all logic on its rising edge.
- SYS_areset  in  1  reset, synchronous, active-high.
- S_AXIS_tvalid  in  1  sample valid.
- S_AXIS_tdata  in  AXIS_TDATA_WIDTH  {chB, chA}.
- S_AXIS_tready  out  1  tied 1.
- EF_enable  in  1  scheduler run enable.
- EF_channel_mask  in  2  bit0 = chA enabled, bit1 = chB enabled.
- EF_log_count  in  5  window length = 2^EF_log_count valid samples.
- EF_shift  in  3  threshold narrowing shift.
- EF_holdoff  in  HOLDOFF_WIDTH  idle cycles between windows.
- EF_lower_threshold_a / EF_upper_threshold_a  out  W  channel A thresholds.
- EF_lower_threshold_b / EF_upper_threshold_b  out  W  channel B thresholds.
- EF_update  out  2  one-cycle strobe per channel when its thresholds change.
- EF_busy  out  1  high in every state except IDLE.
- EF_active_channel  out  1  channel currently or last measured (0 = A).

Behaviour:
- Reset values:
  - All lower thresholds = 0x7FFF (max positive); all upper thresholds = 0x8000 (max negative).
  - EF_update = 0, EF_busy = 0, EF_active_channel = 0, state = IDLE.
  - Round-robin pointer points to A.
- FSM states: IDLE, ARM, MEASURE, PUBLISH, HOLDOFF.
- IDLE:
  - Go to ARM when EF_enable = 1 and EF_channel_mask != 0.
- ARM (1 cycle):
  - Latch EF_log_count, EF_shift, EF_holdoff.
  - Pick the channel: the pointer if its mask bit is set, otherwise the other channel.
  - Set tmp_min = 0x7FFF, tmp_max = 0x8000, sample count = 0. Go to MEASURE.
- MEASURE:
  - Only cycles with tvalid = 1 update tmp_min/tmp_max (signed compare) and the 32-bit count.
  - When an accepted sample brings count to 2^log_count, including that sample, go to PUBLISH.
  - log_count = 0 means a 1-sample window.
- PUBLISH (1 cycle):
  - Uses W+1-bit signed arithmetic:
    - center = (tmp_max + tmp_min) >>> 1.
    - lower = ((tmp_min − center) >>> shift) + center.
    - upper = ((tmp_max − center) >>> shift) + center.
  - Truncate results to W bits; they always fit.
  - Register the results into the selected channel's outputs; the other channel's outputs are held.
  - EF_update[ch] = 1 in the cycle after PUBLISH, the same cycle the new values appear.
  - Advance the pointer to the other channel.
  - Go to HOLDOFF, or directly to ARM if the latched holdoff = 0.
- HOLDOFF:
  - Count exactly holdoff cycles, then go to ARM, or to IDLE if EF_enable = 0 or mask = 0.
- Latency: new thresholds are visible 2 cycles after the last window sample is accepted.
- Config changes (log_count, shift, holdoff, mask) take effect only at the next ARM.
- Mask with one bit set: that channel repeats every window.
- EF_enable deasserted in ARM, MEASURE or HOLDOFF:
  - Go to IDLE next cycle.
  - Discard the partial window; no update strobe; thresholds retained.
- EF_enable deasserted in PUBLISH: PUBLISH completes, then go to IDLE.
- tvalid gaps of any length stall MEASURE without loss.
- Reset asserted mid-window: all outputs return to reset values on the next edge.
- Samples of the non-selected channel are ignored.

Decomposition:
- Package extremum_pkg:
  - State encoding localparams.
  - MAX_POS / MAX_NEG constant functions of W.
  - Channel index constants CH_A = 0, CH_B = 1.
- Sub-module ef_minmax_accumulator:
  - Inputs: clear, sample_valid, W-bit sample, log_count.
  - Outputs: tmp_min, tmp_max, done.
  - The scheduler instantiates it once and muxes the selected channel into it.
- Threshold arithmetic and the FSM stay in extremum_scheduler.

Test Plan:
1. Single channel A, log_count = 2, shift = 0, holdoff = 0; chA samples 10, −20, 5, 30 → EF_update = 01 once; lower_a = −20, upper_a = 30; B outputs stay 0x7FFF/0x8000.
2. Narrowing: mask = 01, log_count = 1, shift = 1; chA samples −100, 100 → center 0; lower_a = −50, upper_a = 50.
3. Round-robin: mask = 11, log_count = 3, holdoff = 5; chA constant 7, chB constant −3 → EF_update alternates 01, 10, 01. Successive strobes are 8 valid samples + 1 ARM + 1 PUBLISH + 5 holdoff cycles apart with tvalid always 1. Thresholds: a = 7/7, b = −3/−3.
4. tvalid gaps: log_count = 2 with tvalid toggling 1,0,1,0… → PUBLISH only after the 4th valid sample. Samples seen while tvalid = 0 (value 1000) do not affect min/max.
5. Abort: deassert EF_enable after 2 of 4 samples → IDLE next cycle; no EF_update; prior thresholds unchanged; EF_busy = 0.
6. Extremes and reset: samples 0x7FFF, 0x8000, shift = 0 → lower = 0x8000, upper = 0x7FFF with no overflow. Then SYS_areset high for 1 cycle mid-window → all outputs at reset values.
